// File: rtl/bcd_seq_ctrl_if.sv
// bcd_seq_ctrl_if: start/busy/done handshake and result bus of the sequential binary-to-BCD converter
interface bcd_seq_ctrl_if #(parameter int BIN_W = 8, parameter int DIGITS = 3);
   logic                  start;
   logic [BIN_W-1:0]      bin_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  overflow;
   modport master (output start, bin_in, input busy, done, bcd_out, overflow);
   modport slave (input start, bin_in, output busy, done, bcd_out, overflow);
endinterface

// File: rtl/bcd_seq_ctrl.sv
// bcd_seq_ctrl: double-dabble binary-to-BCD converter, one bit per clock, start/busy/done handshake.
// Define BCD_SAT_EN to saturate bcd_out to all nines on overflow; otherwise the result wraps modulo 10^DIGITS.
module bcd_seq_ctrl #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input logic            clk,
   input logic            rst_n,
   bcd_seq_ctrl_if.slave  bus
);
   localparam int CW = $clog2(BIN_W + 1);
   localparam int BW = 4 * DIGITS;
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction
   localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;
   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
   state_t           state, state_nxt;
   logic [BIN_W-1:0] bin_sr;
   logic [BW-1:0]    bcd_sr, bcd_adj, res;
   logic [CW-1:0]    cnt;
   logic             ovf;
   assign bus.busy = state != IDLE;
`ifdef BCD_SAT_EN
   assign res = ovf ? {DIGITS{4'h9}} : bcd_sr;
`else
   assign res = bcd_sr;
`endif
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   end
   // next state: accept in IDLE, BIN_W shift steps, one FINISH cycle
   always_comb begin
      state_nxt = state;
      if (state == IDLE) state_nxt = bus.start ? SHIFT : IDLE;
      else if (state == SHIFT) state_nxt = (cnt == CW'(1)) ? FINISH : SHIFT;
      else state_nxt = IDLE;
   end
   // add-3 correction of every digit that is 5 or more, no carry between digits
   always_comb begin
      bcd_adj = bcd_sr;
      for (int i = 0; i < DIGITS; i++)
         bcd_adj[4*i+:4] = (bcd_sr[4*i+:4] >= 4'd5) ? bcd_sr[4*i+:4] + 4'd3 : bcd_sr[4*i+:4];
   end
   // datapath: load operand, shift one bit per cycle, publish result in FINISH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_sr       <= '0;
         bcd_sr       <= '0;
         cnt          <= '0;
         ovf          <= 1'b0;
         bus.done     <= 1'b0;
         bus.bcd_out  <= '0;
         bus.overflow <= 1'b0;
      end else begin
         bus.done <= state == FINISH;
         if (state == IDLE && bus.start) begin
            bin_sr <= bus.bin_in;
            bcd_sr <= '0;
            cnt    <= CW'(BIN_W);
            ovf    <= 64'(bus.bin_in) > MAX_VAL;
         end else if (state == SHIFT) begin
            bcd_sr <= BW'({bcd_adj, bin_sr[BIN_W-1]});
            bin_sr <= bin_sr << 1;
            cnt    <= cnt - CW'(1);
         end else if (state == FINISH) begin
            bus.bcd_out  <= res;
            bus.overflow <= ovf;
         end
      end
   end
endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// tb_bcd_seq_ctrl: scoreboard bench for bcd_seq_ctrl (default build and DIGITS=2 instance)
module tb_bcd_seq_ctrl;
   localparam int BIN_W = 8;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_done = 0;
   int mcnt = 0;
   logic mdone = 1'b0;
   logic [7:0] sb[$];
   logic [7:0] sb_v;
   bcd_seq_ctrl_if #(.BIN_W(BIN_W), .DIGITS(3)) d ();
   bcd_seq_ctrl_if #(.BIN_W(BIN_W), .DIGITS(2)) e ();
   bcd_seq_ctrl #(.BIN_W(BIN_W), .DIGITS(3)) u0 (.clk(clk), .rst_n(rst_n), .bus(d.slave));
   bcd_seq_ctrl #(.BIN_W(BIN_W), .DIGITS(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(e.slave));

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic [11:0] ref3(input int v);
      int m = v % 1000;
      return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   function automatic logic [7:0] ref2(input int v);
      int m = v % 100;
      return {4'(m / 10), 4'(m % 10)};
   endfunction

   // reference timing model: accept when idle, busy for BIN_W+1 edges, done after the last
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcnt = 0;
         mdone = 1'b0;
         sb.delete();
      end else begin
         mdone = (mcnt == 1);
         if (mcnt == 0 && d.start === 1'b1) begin
            sb.push_back(d.bin_in);
            mcnt = BIN_W + 1;
         end else if (mcnt != 0) mcnt--;
      end
   end

   // compare busy/done against the model every cycle, pop the scoreboard on each done
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         checks++;
         if (d.busy !== (mcnt != 0)) begin
            errors++;
            $display("FAIL busy_track cyc=%0d got %b exp %b", cyc, d.busy, mcnt != 0);
         end
         checks++;
         if (d.done !== mdone) begin
            errors++;
            $display("FAIL done_track cyc=%0d got %b exp %b", cyc, d.done, mdone);
         end
         if (d.done === 1'b1) begin
            n_done++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL spurious_done cyc=%0d got done=1 exp no pending request", cyc);
            end else begin
               sb_v = sb.pop_front();
               if (d.bcd_out !== ref3(sb_v) || d.overflow !== 1'b0) begin
                  errors++;
                  $display("FAIL sb_result bin=%0d got %h/%b exp %h/0", sb_v, d.bcd_out, d.overflow, ref3(sb_v));
               end
            end
         end
      end
   end

   task automatic do_conv(input logic [7:0] v, output logic [11:0] r, output logic o, output int lat);
      @(negedge clk);
      d.start = 1'b1;
      d.bin_in = v;
      @(negedge clk);
      d.start = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (d.done !== 1'b1 && lat < 40);
      r = d.bcd_out;
      o = d.overflow;
   endtask

   task automatic do_conv2(input logic [7:0] v, output logic [7:0] r, output logic o, output int lat);
      @(negedge clk);
      e.start = 1'b1;
      e.bin_in = v;
      @(negedge clk);
      e.start = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (e.done !== 1'b1 && lat < 40);
      r = e.bcd_out;
      o = e.overflow;
   endtask

   task automatic test_reset();
      d.start = 1'b0;
      d.bin_in = '0;
      e.start = 1'b0;
      e.bin_in = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({d.busy, d.done, d.bcd_out, d.overflow} !== 15'd0) begin
         errors++;
         $display("FAIL reset_outputs got %b%b%h%b exp all zero", d.busy, d.done, d.bcd_out, d.overflow);
      end
      checks++;
      if ({e.busy, e.done, e.bcd_out, e.overflow} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs2 got %b%b%h%b exp all zero", e.busy, e.done, e.bcd_out, e.overflow);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [11:0] r;
      logic o;
      int lat;
      do_conv(8'd255, r, o, lat);
      checks++;
      if (r !== 12'h255 || o !== 1'b0) begin
         errors++;
         $display("FAIL basic_255 got %h/%b exp 255/0", r, o);
      end
      checks++;
      if (lat != BIN_W + 1) begin
         errors++;
         $display("FAIL basic_latency got %0d exp %0d", lat, BIN_W + 1);
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] r;
      logic o;
      int lat, t1, t2;
      do_conv(8'd0, r, o, lat);
      t1 = cyc;
      checks++;
      if (r !== 12'h000 || lat != BIN_W + 1) begin
         errors++;
         $display("FAIL b2b_zero got %h lat %0d exp 000 lat %0d", r, lat, BIN_W + 1);
      end
      d.start = 1'b1;
      d.bin_in = 8'd99;
      @(posedge clk);
      #1;
      d.start = 1'b0;
      d.bin_in = 8'hAA;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (d.done !== 1'b1 && lat < 40);
      t2 = cyc;
      checks++;
      if (d.bcd_out !== 12'h099) begin
         errors++;
         $display("FAIL b2b_99 got %h exp 099", d.bcd_out);
      end
      checks++;
      if (t2 - t1 != BIN_W + 2) begin
         errors++;
         $display("FAIL b2b_spacing got %0d exp %0d", t2 - t1, BIN_W + 2);
      end
   endtask

   task automatic test_start_held();
      int n0 = n_done;
      @(negedge clk);
      d.start = 1'b1;
      for (int i = 0; i < 30; i++) begin
         d.bin_in = 8'($urandom);
         @(negedge clk);
      end
      d.start = 1'b0;
      repeat (15) @(negedge clk);
      checks++;
      if (n_done - n0 != 3) begin
         errors++;
         $display("FAIL held_done_count got %0d exp 3", n_done - n0);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL held_pending got %0d exp 0", sb.size());
      end
   endtask

   task automatic test_reset_abort();
      logic [11:0] r;
      logic o;
      int lat, n0;
      @(negedge clk);
      d.start = 1'b1;
      d.bin_in = 8'd200;
      @(negedge clk);
      d.start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (d.busy !== 1'b0 || d.done !== 1'b0 || d.bcd_out !== 12'h000) begin
         errors++;
         $display("FAIL abort_outputs got busy=%b done=%b bcd=%h exp 0/0/000", d.busy, d.done, d.bcd_out);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n0 = n_done;
      repeat (15) @(negedge clk);
      checks++;
      if (n_done != n0) begin
         errors++;
         $display("FAIL abort_no_done got %0d dones exp 0", n_done - n0);
      end
      do_conv(8'd37, r, o, lat);
      checks++;
      if (r !== 12'h037 || o !== 1'b0 || lat != BIN_W + 1) begin
         errors++;
         $display("FAIL abort_then_37 got %h/%b lat %0d exp 037/0 lat %0d", r, o, lat, BIN_W + 1);
      end
   endtask

   task automatic test_digits2();
      logic [7:0] r, exp150;
      logic o;
      int lat;
`ifdef BCD_SAT_EN
      exp150 = 8'h99;
`else
      exp150 = 8'h50;
`endif
      do_conv2(8'd150, r, o, lat);
      checks++;
      if (r !== exp150 || o !== 1'b1 || lat != BIN_W + 1) begin
         errors++;
         $display("FAIL d2_150 got %h/%b lat %0d exp %h/1 lat %0d", r, o, lat, exp150, BIN_W + 1);
      end
      do_conv2(8'd99, r, o, lat);
      checks++;
      if (r !== 8'h99 || o !== 1'b0) begin
         errors++;
         $display("FAIL d2_99 got %h/%b exp 99/0", r, o);
      end
      do_conv2(8'd100, r, o, lat);
      checks++;
`ifdef BCD_SAT_EN
      if (r !== 8'h99 || o !== 1'b1) begin
         errors++;
         $display("FAIL d2_100 got %h/%b exp 99/1", r, o);
      end
`else
      if (r !== ref2(100) || o !== 1'b1) begin
         errors++;
         $display("FAIL d2_100 got %h/%b exp %h/1", r, o, ref2(100));
      end
`endif
      do_conv2(8'd47, r, o, lat);
      checks++;
      if (r !== ref2(47) || o !== 1'b0) begin
         errors++;
         $display("FAIL d2_47 got %h/%b exp %h/0", r, o, ref2(47));
      end
   endtask

   task automatic test_sweep();
      logic [11:0] r;
      logic o;
      int lat;
      for (int v = 0; v < 256; v++) begin
         do_conv(8'(v), r, o, lat);
         checks++;
         if (r !== ref3(v) || o !== 1'b0) begin
            errors++;
            $display("FAIL sweep_value bin=%0d got %h/%b exp %h/0", v, r, o, ref3(v));
         end
         checks++;
         if (lat != BIN_W + 1) begin
            errors++;
            $display("FAIL sweep_latency bin=%0d got %0d exp %0d", v, lat, BIN_W + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_start_held();
      test_reset_abort();
      test_digits2();
      test_sweep();
      repeat (12) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL final_pending got %0d exp 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout exp completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end
endmodule
